pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional 2-entry skid buffer and x0 write-enable squash.
// With SKID_EN=1 in_ready is registered so out_ready never reaches upstream combinationally.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 98,
  parameter int RD_W      = 5,
  parameter int SKID_EN   = 1,
  parameter int X0_SQUASH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_regwrite,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_regwrite,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [PAYLOAD_W-1:0]   head_data_q, skid_data_q;
  logic [RD_W-1:0]        head_rd_q, skid_rd_q;
  logic                   head_regwrite_q, skid_regwrite_q;

  logic accept, retire;
  logic head_load_in, head_load_skid, skid_load;

  assign in_ready = (SKID_EN != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = HEAD;
          head_load_in = 1'b1;
        end
      end
      HEAD: begin
        if (accept && retire) begin
          head_load_in = 1'b1;
        end else if (retire) begin
          state_d = EMPTY;
        end else if (accept && (SKID_EN != 0)) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end
      end
      FULL: begin
        // Skid entry slides into the head on the same edge the old head retires.
        if (retire) begin
          state_d        = HEAD;
          head_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including an accept on this edge.
    if (flush) begin
      state_d        = EMPTY;
      head_load_in   = 1'b0;
      head_load_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= EMPTY;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      head_data_q     <= '0;
      head_rd_q       <= '0;
      head_regwrite_q <= 1'b0;
      skid_data_q     <= '0;
      skid_rd_q       <= '0;
      skid_regwrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (head_load_in) begin
        head_data_q     <= in_data;
        head_rd_q       <= in_rd;
        head_regwrite_q <= in_regwrite;
      end else if (head_load_skid) begin
        head_data_q     <= skid_data_q;
        head_rd_q       <= skid_rd_q;
        head_regwrite_q <= skid_regwrite_q;
      end
      if (skid_load) begin
        skid_data_q     <= in_data;
        skid_rd_q       <= in_rd;
        skid_regwrite_q <= in_regwrite;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = head_data_q;
  assign out_rd       = head_rd_q;
  assign out_regwrite = head_regwrite_q && out_valid_q &&
                        !((X0_SQUASH != 0) && (head_rd_q == '0));
  assign occupancy    = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid instance, no-squash instance and single-entry instance.
module tb_pipe_stage_skid;

  localparam int PW = 98;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: SKID_EN=1, X0_SQUASH=1
  logic          a_flush = 0, a_in_valid = 0, a_in_regwrite = 0, a_out_ready = 0;
  logic [PW-1:0] a_in_data = '0;
  logic [RW-1:0] a_in_rd = '0;
  logic          a_in_ready, a_out_valid, a_out_regwrite;
  logic [PW-1:0] a_out_data;
  logic [RW-1:0] a_out_rd;
  logic [1:0]    a_occ;

  // Instance B: SKID_EN=1, X0_SQUASH=0
  logic          b_flush = 0, b_in_valid = 0, b_in_regwrite = 0, b_out_ready = 0;
  logic [PW-1:0] b_in_data = '0;
  logic [RW-1:0] b_in_rd = '0;
  logic          b_in_ready, b_out_valid, b_out_regwrite;
  logic [PW-1:0] b_out_data;
  logic [RW-1:0] b_out_rd;
  logic [1:0]    b_occ;

  // Instance C: SKID_EN=0
  logic          c_flush = 0, c_in_valid = 0, c_in_regwrite = 0, c_out_ready = 0;
  logic [PW-1:0] c_in_data = '0;
  logic [RW-1:0] c_in_rd = '0;
  logic          c_in_ready, c_out_valid, c_out_regwrite;
  logic [PW-1:0] c_out_data;
  logic [RW-1:0] c_out_rd;
  logic [1:0]    c_occ;

  pipe_stage_skid #(.PAYLOAD_W(PW), .RD_W(RW), .SKID_EN(1), .X0_SQUASH(1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_rd(a_in_rd), .in_regwrite(a_in_regwrite),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_rd(a_out_rd), .out_regwrite(a_out_regwrite), .occupancy(a_occ));

  pipe_stage_skid #(.PAYLOAD_W(PW), .RD_W(RW), .SKID_EN(1), .X0_SQUASH(0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_rd(b_in_rd), .in_regwrite(b_in_regwrite),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_rd(b_out_rd), .out_regwrite(b_out_regwrite), .occupancy(b_occ));

  pipe_stage_skid #(.PAYLOAD_W(PW), .RD_W(RW), .SKID_EN(0), .X0_SQUASH(1)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_rd(c_in_rd), .in_regwrite(c_in_regwrite),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_rd(c_out_rd), .out_regwrite(c_out_regwrite), .occupancy(c_occ));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [RW-1:0] rd, input logic rw);
    a_in_valid    = v;
    a_in_rd       = rd;
    a_in_data     = {{(PW-8){1'b0}}, 8'hA0} + PW'(rd);
    a_in_regwrite = rw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 0;
    #1;
    check("rst_occ",       a_occ, 0);
    check("rst_valid",     a_out_valid, 0);
    check("rst_regwrite",  a_out_regwrite, 0);
    check("rst_data",      a_out_data, 0);
    check("rst_rd",        a_out_rd, 0);
    check("rst_in_ready",  a_in_ready, 1);

    // Streaming: 4 back-to-back entries, downstream always ready
    a_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      a_drive(1, RW'(i), 1);
      tick();
      check("stream_valid", a_out_valid, 1);
      check("stream_rd",    a_out_rd, i);
      check("stream_data",  a_out_data, 128'hA0 + i);
      check("stream_rw",    a_out_regwrite, 1);
      check("stream_occ",   a_occ, 1);
    end
    a_drive(0, 0, 0);
    tick();
    check("stream_drain_valid", a_out_valid, 0);
    check("stream_drain_occ",   a_occ, 0);
    check("stream_drain_rw",    a_out_regwrite, 0);
    check("stream_hold_rd",     a_out_rd, 4);

    // Backpressure into the skid slot
    a_out_ready = 0;
    a_drive(1, 5, 1);
    tick();
    check("bp_occ1",   a_occ, 1);
    check("bp_ready1", a_in_ready, 1);
    a_drive(1, 6, 1);
    tick();
    check("bp_occ2",   a_occ, 2);
    check("bp_ready2", a_in_ready, 0);
    check("bp_head5",  a_out_rd, 5);
    a_drive(1, 7, 1);
    tick();
    check("bp_full_occ",  a_occ, 2);
    check("bp_full_head", a_out_rd, 5);
    check("bp_full_data", a_out_data, 128'hA5);
    a_drive(0, 0, 0);
    a_out_ready = 1;
    tick();
    check("bp_ret_rd",    a_out_rd, 6);
    check("bp_ret_occ",   a_occ, 1);
    check("bp_ret_ready", a_in_ready, 1);
    tick();
    check("bp_empty_valid", a_out_valid, 0);
    check("bp_empty_rd",    a_out_rd, 6);

    // x0 squash on A, no squash on B
    a_out_ready = 0;
    a_drive(1, 0, 1);
    b_in_valid = 1; b_in_rd = 0; b_in_regwrite = 1; b_in_data = '0;
    tick();
    a_drive(0, 0, 0);
    b_in_valid = 0;
    check("x0_a_valid", a_out_valid, 1);
    check("x0_a_rw",    a_out_regwrite, 0);
    check("x0_b_valid", b_out_valid, 1);
    check("x0_b_rw",    b_out_regwrite, 1);
    a_out_ready = 1;
    tick();
    a_out_ready = 0;

    // Flush while FULL, with an upstream entry offered
    a_drive(1, 8, 1);  tick();
    a_drive(1, 9, 1);  tick();
    check("fl_full_occ", a_occ, 2);
    a_drive(1, 10, 1);
    a_flush = 1;
    tick();
    a_flush = 0;
    a_drive(0, 0, 0);
    check("fl_occ",      a_occ, 0);
    check("fl_valid",    a_out_valid, 0);
    check("fl_in_ready", a_in_ready, 1);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_ghost", a_out_valid, 0);
    end
    // Flush from EMPTY beats a simultaneous accept
    a_drive(1, 11, 1);
    a_flush = 1;
    tick();
    a_flush = 0;
    a_drive(0, 0, 0);
    check("fl_acc_occ",   a_occ, 0);
    check("fl_acc_valid", a_out_valid, 0);

    // SKID_EN=0 instance: combinational in_ready
    c_in_valid = 1; c_in_rd = 1; c_in_regwrite = 1; c_in_data = 1; c_out_ready = 0;
    tick();
    check("c_head_valid", c_out_valid, 1);
    check("c_head_rd",    c_out_rd, 1);
    check("c_ready_bp",   c_in_ready, 0);
    c_in_rd = 3;
    tick();
    check("c_hold_rd",  c_out_rd, 1);
    check("c_hold_occ", c_occ, 1);
    c_out_ready = 1;
    #1;
    check("c_ready_comb", c_in_ready, 1);
    c_in_rd = 2;
    tick();
    check("c_pass_rd",  c_out_rd, 2);
    check("c_pass_occ", c_occ, 1);
    c_in_valid = 0;
    tick();
    check("c_drain_occ", c_occ, 0);

    // Reset mid-operation from FULL; in_valid during reset must be ignored
    a_out_ready = 0;
    a_drive(1, 12, 1); tick();
    a_drive(1, 13, 1); tick();
    check("rm_full_occ", a_occ, 2);
    a_drive(1, 15, 1);
    rst = 1;
    tick();
    rst = 0;
    a_drive(0, 0, 0);
    check("rm_occ",      a_occ, 0);
    check("rm_valid",    a_out_valid, 0);
    check("rm_rw",       a_out_regwrite, 0);
    check("rm_data",     a_out_data, 0);
    check("rm_rd",       a_out_rd, 0);
    check("rm_in_ready", a_in_ready, 1);
    a_out_ready = 1;
    a_drive(1, 14, 1);
    tick();
    a_drive(0, 0, 0);
    check("rm_first_valid", a_out_valid, 1);
    check("rm_first_rd",    a_out_rd, 14);
    check("rm_first_occ",   a_occ, 1);
    tick();
    check("rm_alone_valid", a_out_valid, 0);
    check("rm_alone_occ",   a_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
